// File: rtl/frame_serializer_pkg.sv
// Shared types and constants for the frame serializer.
// State encoding, data width and default bit period.
package frame_serializer_pkg;

    localparam int DATA_W      = 8;
    localparam int BIT_DIV_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/frame_serializer_bit_tick_gen.sv
// Bit period timer: one-cycle tick every BIT_DIV cycles.
// restart holds the count at zero so the next bit starts a full period.
module bit_tick_gen #(
    parameter int BIT_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

    logic [7:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RST || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Serializes one byte per frame: start, 8 data bits MSB first,
// optional even parity, stop. OUT and BUSY are registered.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int BIT_DIV   = BIT_DIV_DEF,
    parameter int PARITY_EN = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              OUT,
    output logic              BUSY
);

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [2:0]        idx, idx_n;
    logic              par, par_n;
    logic              out_r, out_n;
    logic              busy_r, busy_n;
    logic              restart;
    logic              tick;
    logic              accept;
    logic              msb;

    bit_tick_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_tick (
        .CLK     (CLK),
        .RST     (RST),
        .restart (restart),
        .tick    (tick)
    );

    assign IN_READY = (state == IDLE) && !RST;
    assign accept   = IN_VALID && IN_READY;
    assign msb      = shreg[DATA_W-1];
    assign OUT      = out_r;
    assign BUSY     = busy_r;

    // Each transition loads the line level for the state being entered.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        par_n   = par;
        out_n   = out_r;
        busy_n  = busy_r;
        restart = 1'b0;
        unique case (state)
            IDLE: begin
                restart = 1'b1;
                if (accept) begin
                    state_n = START;
                    shreg_n = IN_DATA;
                    idx_n   = '0;
                    par_n   = 1'b0;
                    out_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    out_n   = msb;
                    par_n   = par ^ msb;
                    shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            out_n   = par;
                        end else begin
                            state_n = STOP;
                            out_n   = 1'b1;
                        end
                    end else begin
                        idx_n   = idx + 3'd1;
                        out_n   = msb;
                        par_n   = par ^ msb;
                        shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    out_n   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    out_n   = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            par    <= 1'b0;
            out_r  <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            idx    <= idx_n;
            par    <= par_n;
            out_r  <= out_n;
            busy_r <= busy_n;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench: three instances (4/parity, 4/no parity, 1/parity).
// Drivers push expected bytes; per-instance monitors check serial frames.
module tb_frame_serializer;

    logic       clk;
    logic       rst_w   [3];
    logic       valid_w [3];
    logic [7:0] data_w  [3];
    logic       rdy_w   [3];
    logic       out_w   [3];
    logic       busy_w  [3];

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    frame_serializer #(.BIT_DIV(4), .PARITY_EN(1)) dut_a (
        .CLK(clk), .RST(rst_w[0]), .IN_DATA(data_w[0]), .IN_VALID(valid_w[0]),
        .IN_READY(rdy_w[0]), .OUT(out_w[0]), .BUSY(busy_w[0]));

    frame_serializer #(.BIT_DIV(4), .PARITY_EN(0)) dut_b (
        .CLK(clk), .RST(rst_w[1]), .IN_DATA(data_w[1]), .IN_VALID(valid_w[1]),
        .IN_READY(rdy_w[1]), .OUT(out_w[1]), .BUSY(busy_w[1]));

    frame_serializer #(.BIT_DIV(1), .PARITY_EN(1)) dut_c (
        .CLK(clk), .RST(rst_w[2]), .IN_DATA(data_w[2]), .IN_VALID(valid_w[2]),
        .IN_READY(rdy_w[2]), .OUT(out_w[2]), .BUSY(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void qpush(input int k, input logic [7:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Frame bit b: 0 start, 1..8 data MSB first, 9 parity if enabled, last stop.
    function automatic logic expbit(input logic [7:0] d, input int b, input int pen);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[8-b];
        if (pen != 0 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic mon(input int k, input int div, input int pen);
        logic       prev;
        logic       abort;
        logic       busy_ok;
        logic       seen;
        logic       e;
        logic [7:0] d;
        int         nb;
        nb   = 10 + pen;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_w[k] && !prev && !rst_w[k]) begin
                abort   = 1'b0;
                busy_ok = 1'b1;
                d       = 8'h00;
                if (qsize(k) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame dut%0d", k);
                end else begin
                    d = qpop(k);
                end
                for (int b = 0; b < nb; b++) begin
                    e    = expbit(d, b, pen);
                    seen = e;
                    for (int c = 0; c < div; c++) begin
                        if (rst_w[k]) begin
                            abort = 1'b1;
                            break;
                        end
                        if (out_w[k] !== e) seen = out_w[k];
                        if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
                        @(negedge clk);
                    end
                    if (abort) break;
                    chk($sformatf("dut%0d_%02h_bit%0d", k, d, b), {31'd0, seen}, {31'd0, e});
                end
                if (abort) begin
                    while (rst_w[k]) @(negedge clk);
                end else begin
                    chk($sformatf("dut%0d_%02h_busy_held", k, d), {31'd0, busy_ok}, 32'd1);
                    chk($sformatf("dut%0d_%02h_ready_at_len", k, d), {31'd0, rdy_w[k]}, 32'd1);
                end
                prev = busy_w[k];
            end else begin
                prev = busy_w[k];
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic keep);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy_w[k] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_w[k]) begin
            chk($sformatf("dut%0d_ready_timeout", k), 32'd0, 32'd1);
            return;
        end
        valid_w[k] = 1'b1;
        data_w[k]  = d;
        qpush(k, d);
        @(posedge clk);
        #1;
        if (!keep) valid_w[k] = 1'b0;
    endtask

    initial mon(0, 4, 1);
    initial mon(1, 4, 0);
    initial mon(2, 1, 1);

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_cmp++;
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic ok_out, ok_busy, ok_rdy;
        int   t;
        for (int k = 0; k < 3; k++) begin
            rst_w[k]   = 1'b1;
            valid_w[k] = 1'b0;
            data_w[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        valid_w[0] = 1'b1;
        #1;
        chk("reset_out", {31'd0, out_w[0]}, 32'd1);
        chk("reset_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("reset_ready", {31'd0, rdy_w[0]}, 32'd0);
        @(posedge clk);
        #1;
        valid_w[0] = 1'b0;
        for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;

        ok_out = 1'b1; ok_busy = 1'b1; ok_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_w[0] !== 1'b1) ok_out = 1'b0;
            if (busy_w[0] !== 1'b0) ok_busy = 1'b0;
            if (rdy_w[0] !== 1'b1) ok_rdy = 1'b0;
        end
        chk("idle_out_high", {31'd0, ok_out}, 32'd1);
        chk("idle_busy_low", {31'd0, ok_busy}, 32'd1);
        chk("idle_ready_high", {31'd0, ok_rdy}, 32'd1);

        send(0, 8'hA5, 1'b0);

        send(0, 8'h55, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        data_w[0] = 8'hAA;

        send(0, 8'h3C, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst_w[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out", {31'd0, out_w[0]}, 32'd1);
        chk("midreset_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("midreset_ready", {31'd0, rdy_w[0]}, 32'd0);
        rst_w[0] = 1'b0;
        #1;
        chk("postreset_ready", {31'd0, rdy_w[0]}, 32'd1);
        ok_out = 1'b1; ok_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_w[0] !== 1'b1) ok_out = 1'b0;
            if (busy_w[0] !== 1'b0) ok_busy = 1'b0;
        end
        chk("postreset_line_idle", {31'd0, ok_out}, 32'd1);
        chk("postreset_no_resend", {31'd0, ok_busy}, 32'd1);

        send(1, 8'h01, 1'b0);

        send(2, 8'hFF, 1'b1);
        data_w[2] = 8'h00;
        send(2, 8'h00, 1'b0);

        t = 0;
        while ((qsize(0) + qsize(1) + qsize(2) > 0 ||
                busy_w[0] || busy_w[1] || busy_w[2]) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_done", {31'd0, (t < 1000)}, 32'd1);
        chk("queues_empty", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter BIT_DIV, default 4, sets the clock cycles per serial bit; legal values are 1..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit, 0 omits it.
REQ-003 Port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port RST  input  1  reset; synchronous and active-high.
REQ-005 Port IN_DATA  input  8  parallel word to transmit.
REQ-006 Port IN_VALID  input  1  IN_DATA holds a word to send.
REQ-007 Port IN_READY  output  1  the block can accept a word this cycle.
REQ-008 Port OUT  output  1  serial line; idle level is high.
REQ-009 Port BUSY  output  1  a frame is in progress.

Function
REQ-010 The block SHALL run the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; when PARITY_EN=0, DATA goes directly to STOP.
REQ-011 IN_READY SHALL be 1 exactly when the state is IDLE and RST is 0; it is decoded from the registered state.
REQ-012 A word SHALL be accepted on a rising edge where IN_VALID=1 and IN_READY=1; IN_DATA is latched into an 8-bit shift register on that edge.
REQ-013 On the accept edge, the block SHALL enter START, driving OUT=0 and BUSY=1 from that edge onward.
REQ-014 Each bit SHALL be held for exactly BIT_DIV cycles, timed by a counter that restarts at every bit boundary.
REQ-015 DATA SHALL emit the 8 bits MSB first.
REQ-016 PARITY SHALL emit the XOR of the 8 latched bits (even parity).
REQ-017 STOP SHALL emit OUT=1 for BIT_DIV cycles and then return to IDLE; IN_READY rises on the same edge that BUSY falls.
REQ-018 Frame length SHALL be (10+PARITY_EN)*BIT_DIV cycles from the accept edge to the edge where IN_READY is 1 again.
REQ-019 With IN_VALID held high, consecutive frames SHALL run back-to-back with zero idle cycles: the next accept occurs on the first IDLE cycle.
REQ-020 Changes on IN_DATA or IN_VALID while BUSY=1 SHALL have no effect on the frame in progress.
REQ-021 With BIT_DIV=1, each bit SHALL last exactly one cycle, with no skipped or duplicated bits.
REQ-022 OUT and BUSY SHALL be registered outputs, free of glitches and combinational paths from the inputs.

Reset
REQ-023 With RST=1 at a rising edge, the block SHALL set state=IDLE, OUT=1, BUSY=0, bit counter=0, shift register=0, and bit index=0.
REQ-024 IN_READY SHALL be 0 while RST=1, and the block SHALL accept no word during a reset cycle.
REQ-025 A reset mid-frame SHALL abort the frame: the partial frame is discarded, OUT=1 from the next edge, and no word is resent after reset.

Structure
REQ-026 The shared package SHALL hold the FSM state enum (IDLE, START, DATA, PARITY, STOP), DATA_W=8, and the default BIT_DIV.
REQ-027 Bit timing SHALL live in one sub-module, bit_tick_gen, which has ports CLK, RST, and restart, and outputs a one-cycle tick every BIT_DIV cycles.
REQ-028 The top level SHALL contain only the FSM, the shift register, the bit index, and the parity accumulator; the expected RTL size is 150-250 lines.

Verification
REQ-029 BIT_DIV=4, PARITY_EN=1, send 0xA5 -> OUT = 0, 1,0,1,0,0,1,0,1, parity 0, then 1, each bit 4 cycles; IN_READY rises 44 cycles after the accept edge.
REQ-030 PARITY_EN=0, send 0x01 -> 40-cycle frame with no parity bit; the last data bit is 1 and the stop bit is 1.
REQ-031 BIT_DIV=1, IN_VALID held high with 0xFF then 0x00 -> two 11-cycle frames back-to-back with no idle cycle; parity bits are 0 and 0.
REQ-032 Assert RST for 1 cycle at cycle 13 of a 0x3C frame -> OUT=1, BUSY=0, and IN_READY=0 during reset, then IN_READY=1; the line stays idle until a new IN_VALID.
REQ-033 Change IN_DATA from 0x55 to 0xAA 2 cycles after accept -> the serial stream still carries 0x55.
REQ-034 Hold IN_VALID=0 for 20 cycles after reset -> OUT stays 1, BUSY stays 0, and IN_READY stays 1.
